// File: rtl/ucsbece154b_icache_assoc.sv
// N-way set-associative instruction cache: block fill from SDRAM, invalid-first/LFSR replacement, global invalidate.
// Optional macro ICACHE_EARLY_RESTART_EN forwards the missed word straight from the burst during FILL.
module ucsbece154b_icache_assoc #(
  parameter int          NUM_SETS    = 8,
  parameter int          NUM_WAYS    = 4,
  parameter int          BLOCK_WORDS = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        readEnable,
  input  logic [31:0] readAddress,
  output logic [31:0] instruction,
  output logic        ready,
  output logic        busy,
  input  logic        invalidate,
  input  logic [31:0] memDataIn,
  input  logic        memDataReady,
  output logic [31:0] memReadAddress,
  output logic        memReadRequest
);
  localparam int CW    = $clog2(BLOCK_WORDS);
  localparam int IDX   = $clog2(NUM_SETS);
  localparam int WW    = $clog2(NUM_WAYS);
  localparam int OFF   = CW + 2;
  localparam int TAG_W = 32 - OFF - IDX;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_READ, S_MISS, S_FILL, S_COMMIT} state_t;

  state_t                             state;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  valid;
  logic [TAG_W-1:0]                   tag_arr  [NUM_SETS][NUM_WAYS];
  logic [31:0]                        data_arr [NUM_SETS][NUM_WAYS][BLOCK_WORDS];
  logic [31:0]                        fill_buf [BLOCK_WORDS];
  logic [CW-1:0]                      fill_cnt;
  logic [15:0]                        lfsr;
  logic [15:0]                        lfsr_next;
  logic [29:0]                        miss_addr;
  logic                               stale;

  logic [TAG_W-1:0] rd_tag;
  logic [IDX-1:0]   rd_set;
  logic [CW-1:0]    rd_word;
  logic [TAG_W-1:0] miss_tag;
  logic [IDX-1:0]   miss_set;
  logic [CW-1:0]    miss_word;
  logic             hit;
  logic [WW-1:0]    hit_way;
  logic [WW-1:0]    victim;
  logic             capture;
  logic             early_fwd;
  logic             unused_ok;

  assign rd_tag    = readAddress[31:OFF+IDX];
  assign rd_set    = readAddress[OFF+IDX-1:OFF];
  assign rd_word   = readAddress[OFF-1:2];
  assign miss_tag  = miss_addr[29:CW+IDX];
  assign miss_set  = miss_addr[CW+IDX-1:CW];
  assign miss_word = miss_addr[CW-1:0];
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign capture   = memDataReady && (state == S_MISS || state == S_FILL);
  assign unused_ok = ^{readAddress[1:0], miss_word};

  // Scan downward so the lowest matching way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[rd_set][w] && tag_arr[rd_set][w] == rd_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  always_comb begin
    victim = lfsr[WW-1:0];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[miss_set][w]) victim = WW'(w);
    end
  end

`ifdef ICACHE_EARLY_RESTART_EN
  assign early_fwd = (state == S_FILL) && memDataReady && readEnable &&
                     (readAddress[31:2] == miss_addr) && (fill_cnt == miss_word);
`else
  assign early_fwd = 1'b0;
`endif

  always_comb begin
    ready       = 1'b0;
    instruction = NOP;
    if (state == S_READ && readEnable && hit) begin
      ready       = 1'b1;
      instruction = data_arr[rd_set][hit_way][rd_word];
    end else if (early_fwd) begin
      ready       = 1'b1;
      instruction = memDataIn;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_READ;
      valid          <= '0;
      busy           <= 1'b0;
      memReadRequest <= 1'b0;
      memReadAddress <= '0;
      fill_cnt       <= '0;
      lfsr           <= LFSR_SEED;
      miss_addr      <= '0;
      stale          <= 1'b0;
    end else begin
      if (invalidate) valid <= '0;
      case (state)
        S_READ: begin
          if (readEnable && !hit) begin
            miss_addr      <= readAddress[31:2];
            memReadAddress <= {readAddress[31:OFF], {OFF{1'b0}}};
            lfsr           <= lfsr_next;
            stale          <= 1'b0;
            busy           <= 1'b1;
            memReadRequest <= 1'b1;
            state          <= S_MISS;
          end
        end
        S_MISS: begin
          if (invalidate) stale <= 1'b1;
          if (memDataReady) begin
            fill_cnt       <= fill_cnt + CW'(1);
            memReadRequest <= 1'b0;
            state          <= S_FILL;
          end
        end
        S_FILL: begin
          if (invalidate) stale <= 1'b1;
          if (memDataReady) begin
            fill_cnt <= fill_cnt + CW'(1);
            if (fill_cnt == CW'(BLOCK_WORDS - 1)) state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          // A block fetched across an invalidate is stale and must not become visible.
          if (!invalidate && !stale) valid[miss_set][victim] <= 1'b1;
          busy  <= 1'b0;
          state <= S_READ;
        end
        default: state <= S_READ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (capture) fill_buf[fill_cnt] <= memDataIn;
    if (state == S_COMMIT) begin
      tag_arr[miss_set][victim] <= miss_tag;
      for (int k = 0; k < BLOCK_WORDS; k++) data_arr[miss_set][victim][k] <= fill_buf[k];
    end
  end

endmodule

// File: tb/tb_ucsbece154b_icache_assoc.sv
// Directed bench for ucsbece154b_icache_assoc with a block-level cache model checked every cycle.
module tb_ucsbece154b_icache_assoc;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        readEnable = 1'b0;
  logic [31:0] readAddress = '0;
  logic        invalidate = 1'b0;
  logic [31:0] memDataIn = '0;
  logic        memDataReady = 1'b0;
  logic [31:0] instruction;
  logic        ready;
  logic        busy;
  logic [31:0] memReadAddress;
  logic        memReadRequest;

  int total = 0;
  int bad = 0;
  bit started = 0;

  always #5 clk = ~clk;

  ucsbece154b_icache_assoc dut (
    .clk(clk), .reset_n(reset_n), .readEnable(readEnable), .readAddress(readAddress),
    .instruction(instruction), .ready(ready), .busy(busy), .invalidate(invalidate),
    .memDataIn(memDataIn), .memDataReady(memDataReady),
    .memReadAddress(memReadAddress), .memReadRequest(memReadRequest)
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hA000_0000 | {a[31:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Block-level model: 8 sets x 4 ways x 4 words, ways remember their block number.
  bit          m_valid [8][4];
  logic [31:0] m_blk   [8][4];
  logic [31:0] m_data  [8][4][4];
  logic [31:0] m_buf   [4];
  logic [15:0] m_lfsr;
  logic [31:0] m_pend;
  logic [31:0] m_mra;
  int          m_phase;
  int          m_got;
  bit          m_stale;
  bit          m_seen;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] fb;
    fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 16'h1;
    return (l << 1) | fb;
  endfunction

  function automatic bit m_hit(input logic [31:0] a, output logic [31:0] w);
    int s;
    s = int'((a >> 4) & 32'h7);
    w = NOP;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[s][i] && m_blk[s][i] == (a >> 4)) begin
        w = m_data[s][i][int'((a >> 2) & 32'h3)];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always begin
    bit          inv;
    logic [31:0] dmy;
    int          s;
    int          v;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++) m_valid[i][j] = 0;
      m_lfsr = 16'hACE1; m_phase = 0; m_got = 0; m_stale = 0; m_seen = 0; m_mra = 0;
    end else begin
      inv = invalidate;
      if (m_phase == 0) begin
        if (readEnable && !m_hit(readAddress, dmy)) begin
          m_pend = readAddress; m_mra = readAddress & ~32'hF; m_lfsr = lfsr_step(m_lfsr);
          m_stale = 0; m_seen = 1; m_got = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (inv) m_stale = 1;
        if (memDataReady) begin m_buf[0] = memDataIn; m_got = 1; m_phase = 2; end
      end else if (m_phase == 2) begin
        if (inv) m_stale = 1;
        if (memDataReady) begin
          m_buf[m_got] = memDataIn; m_got++;
          if (m_got == 4) m_phase = 3;
        end
      end else begin
        s = int'((m_pend >> 4) & 32'h7);
        v = -1;
        for (int i = 0; i < 4; i++) if (v < 0 && !m_valid[s][i]) v = i;
        if (v < 0) v = int'(m_lfsr & 16'h3);
        m_blk[s][v] = m_pend >> 4;
        for (int k = 0; k < 4; k++) m_data[s][v][k] = m_buf[k];
        m_valid[s][v] = !(inv || m_stale);
        m_phase = 0;
      end
      if (inv) for (int i = 0; i < 8; i++) for (int j = 0; j < 4; j++) m_valid[i][j] = 0;
    end
  end

  always begin
    bit          e_rdy;
    logic [31:0] e_ins;
    logic [31:0] hw;
    @(negedge clk);
    if (started) begin
      e_rdy = 0; e_ins = NOP;
      if (m_phase == 0) begin
        if (readEnable && m_hit(readAddress, hw)) begin e_rdy = 1; e_ins = hw; end
      end
`ifdef ICACHE_EARLY_RESTART_EN
      else if (m_phase == 2 && memDataReady && readEnable && (readAddress >> 2) == (m_pend >> 2) &&
               m_got == int'((m_pend >> 2) & 32'h3)) begin
        e_rdy = 1; e_ins = memDataIn;
      end
`endif
      chk("ready", {31'b0, ready}, {31'b0, e_rdy});
      chk("instruction", instruction, e_ins);
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      chk("memReadRequest", {31'b0, memReadRequest}, {31'b0, m_phase == 1});
      if (m_phase == 1 || !m_seen) chk("memReadAddress", memReadAddress, m_mra);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    readEnable = 0; invalidate = 0; memDataReady = 0; memDataIn = 0;
    reset_n = 0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mrr", {31'b0, memReadRequest}, 32'd0);
    chk("rst_mra", memReadAddress, 32'd0);
    tick(); tick();
    reset_n = 1;
    tick();
  endtask

  // Serves one 4-word burst; DUT is in COMMIT when this returns.
  task automatic burst(input logic [31:0] blk, input int gap_at, input int inval_at);
    int n;
    n = 0;
    while (!memReadRequest && n < 20) begin tick(); n++; end
    chk("mrr_wait", {31'b0, memReadRequest}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      memDataReady = 1; memDataIn = memw(blk + 32'(4 * k)); invalidate = (k == inval_at);
      tick();
      invalidate = 0;
      if (k == gap_at) begin memDataReady = 0; memDataIn = 32'hDEAD_BEEF; tick(); end
    end
    memDataReady = 0; memDataIn = 0;
  endtask

  task automatic miss_fill(input logic [31:0] a);
    readEnable = 1; readAddress = a;
    tick();
    burst(a & ~32'hF, -1, -1);
    tick();
    chk("refill_hit", {31'b0, ready}, 32'd1);
    chk("refill_word", instruction, memw(a));
    readEnable = 0;
    tick();
  endtask

  task automatic probe(input string name, input logic [31:0] a, input bit exp);
    readEnable = 1; readAddress = a;
    #1;
    chk(name, {31'b0, ready}, {31'b0, exp});
    readEnable = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    reset_n = 0;
    started = 1;
    do_reset();

    // First miss, fill and same-cycle hit.
    readEnable = 1; readAddress = 32'h100;
    #1;
    chk("first_ready", {31'b0, ready}, 32'd0);
    chk("first_nop", instruction, NOP);
    tick();
    chk("miss_mrr", {31'b0, memReadRequest}, 32'd1);
    chk("miss_mra", memReadAddress, 32'h100);
    burst(32'h100, -1, -1);
    chk("commit_busy", {31'b0, busy}, 32'd1);
    tick();
    chk("a0_ready", {31'b0, ready}, 32'd1);
    chk("a0_word", instruction, 32'hA000_0100);
    readAddress = 32'h10C;
    #1;
    chk("a3_word", instruction, 32'hA000_010C);
    readEnable = 0;
    tick();

    // Fill set 0 with four tags, then a fifth evicts the LFSR-chosen way.
    do_reset();
    miss_fill(32'h000); miss_fill(32'h080); miss_fill(32'h100); miss_fill(32'h180);
    miss_fill(32'h200);
    chk("lfsr_model", {16'b0, m_lfsr}, 32'h0000_9C3C);
    probe("keep_080", 32'h084, 1);
    probe("keep_100", 32'h108, 1);
    probe("keep_180", 32'h18C, 1);
    probe("keep_200", 32'h200, 1);
    probe("evict_000", 32'h000, 0);

    // Invalidate mid-fill with a gap in the burst: block must not install.
    readEnable = 1; readAddress = 32'h300;
    tick();
    burst(32'h300, 1, 1);
    tick();
    readEnable = 0;
    probe("stale_300", 32'h300, 0);
    probe("cleared_100", 32'h100, 0);

    // Invalidate coinciding with COMMIT wins.
    readEnable = 1; readAddress = 32'h100;
    tick();
    burst(32'h100, -1, -1);
    invalidate = 1;
    tick();
    invalidate = 0;
    readEnable = 0;
    probe("commit_inval", 32'h100, 0);

    // Lookup in the invalidate cycle still sees the old valid bits.
    miss_fill(32'h100);
    readEnable = 1; readAddress = 32'h104; invalidate = 1;
    #1;
    chk("preclear_hit", {31'b0, ready}, 32'd1);
    readEnable = 0;
    tick();
    invalidate = 0;
    probe("postclear_miss", 32'h104, 0);

    // Reset during word 2 of a fill.
    miss_fill(32'h200);
    readEnable = 1; readAddress = 32'h140;
    tick();
    for (int k = 0; k < 2; k++) begin
      memDataReady = 1; memDataIn = memw(32'h140 + 32'(4 * k));
      tick();
    end
    memDataReady = 1; memDataIn = memw(32'h148);
    #2;
    reset_n = 0;
    #1;
    chk("rfill_busy", {31'b0, busy}, 32'd0);
    chk("rfill_mrr", {31'b0, memReadRequest}, 32'd0);
    memDataReady = 0; readEnable = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    probe("post_rst_200", 32'h200, 0);
    probe("post_rst_140", 32'h140, 0);

    // Early restart on 0x108: word 2 arrives in the third burst cycle.
    readEnable = 1; readAddress = 32'h108;
    tick();
    for (int k = 0; k < 4; k++) begin
      memDataReady = 1; memDataIn = memw(32'h100 + 32'(4 * k));
      #1;
      if (k == 2) begin
`ifdef ICACHE_EARLY_RESTART_EN
        chk("early_ready", {31'b0, ready}, 32'd1);
        chk("early_word", instruction, 32'hA000_0108);
`else
        chk("early_ready", {31'b0, ready}, 32'd0);
        chk("early_word", instruction, NOP);
`endif
      end
      tick();
    end
    memDataReady = 0; memDataIn = 0;
    chk("er_commit_ready", {31'b0, ready}, 32'd0);
    tick();
    chk("er_after_ready", {31'b0, ready}, 32'd1);
    chk("er_after_word", instruction, 32'hA000_0108);
    readEnable = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
